// File: rtl/chip_dispense_sequencer.sv
// -----------------------------------------------------------------------------
// chip_dispense_sequencer
//
// Purpose: drives the dispensing solenoid one chip at a time after a start
// edge, confirms each drop on the chip-drop sensor, and reports progress and
// faults (tube empty, jam / sensor timeout).
//
// Ports:
//   clock          in   system clock, rising edge
//   resetN         in   synchronous active-low reset
//   startIn        in   start level; only its rising edge starts a dispense
//   quantityIn[1:0] in  quantity code: 00=1, 01=5, 10=10, 11=20 chips
//   chipSense      in   chip-drop sensor; a rising edge is one chip
//   tubeEmpty      in   high when the chip tube is empty
//   clearFault     in   level; clears a held fault
//   solenoid       out  dispense actuator drive
//   busy           out  high while a dispense is in progress
//   done           out  one-cycle pulse when the quantity has been dispensed
//   fault[1:0]     out  00 none, 01 tube empty, 10 jam
//   dispensedCount[4:0] out  chips confirmed in current / most recent dispense
// -----------------------------------------------------------------------------
module chip_dispense_sequencer #(
   parameter int PULSE_ON      = 50,
   parameter int PULSE_OFF     = 50,
   parameter int SENSE_TIMEOUT = 200,
   parameter int TIMER_W       = 8
) (
   input  logic       clock,
   input  logic       resetN,
   input  logic       startIn,
   input  logic [1:0] quantityIn,
   input  logic       chipSense,
   input  logic       tubeEmpty,
   input  logic       clearFault,
   output logic       solenoid,
   output logic       busy,
   output logic       done,
   output logic [1:0] fault,
   output logic [4:0] dispensedCount
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PULSE,
      S_WAIT_SENSE,
      S_GAP,
      S_DONE,
      S_FAULT
   } state_t;

   localparam logic [1:0] FAULT_NONE  = 2'b00;
   localparam logic [1:0] FAULT_EMPTY = 2'b01;
   localparam logic [1:0] FAULT_JAM   = 2'b10;

   localparam logic [TIMER_W-1:0] PULSE_LAST = TIMER_W'(PULSE_ON - 1);
   localparam logic [TIMER_W-1:0] GAP_LAST   = TIMER_W'(PULSE_OFF - 1);
   localparam logic [TIMER_W-1:0] TIMEOUT_T  = TIMER_W'(SENSE_TIMEOUT);

   state_t              state_q, state_d;
   logic                solenoid_q, solenoid_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic [1:0]          fault_q, fault_d;
   logic [4:0]          count_q, count_d;
   logic [4:0]          target_q, target_d;
   logic [TIMER_W-1:0]  timer_q, timer_d;
   logic                sensed_q, sensed_d;
   logic                start_prev_q, start_prev_d;
   logic                sense_prev_q, sense_prev_d;

   logic                start_edge;
   logic                sense_edge;
   logic                sense_hit;
   logic [TIMER_W-1:0]  timer_inc;

   function automatic logic [4:0] decode_qty(input logic [1:0] code);
      logic [4:0] n;
      case (code)
         2'b00:   n = 5'd1;
         2'b01:   n = 5'd5;
         2'b10:   n = 5'd10;
         default: n = 5'd20;
      endcase
      return n;
   endfunction

   assign start_edge = startIn & ~start_prev_q;
   assign sense_edge = chipSense & ~sense_prev_q;
   // Only the first sensor edge of each chip counts.
   assign sense_hit  = sense_edge & ~sensed_q;
   assign timer_inc  = timer_q + TIMER_W'(1);

   always_comb begin
      state_d      = state_q;
      solenoid_d   = solenoid_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      fault_d      = fault_q;
      count_d      = count_q;
      target_d     = target_q;
      timer_d      = timer_q;
      sensed_d     = sensed_q;
      start_prev_d = startIn;
      sense_prev_d = chipSense;

      case (state_q)
         S_IDLE: begin
            if (start_edge && (fault_q == FAULT_NONE)) begin
               target_d = decode_qty(quantityIn);
               count_d  = 5'd0;
               if (tubeEmpty) begin
                  state_d = S_FAULT;
                  fault_d = FAULT_EMPTY;
               end else begin
                  state_d    = S_PULSE;
                  timer_d    = '0;
                  sensed_d   = 1'b0;
                  solenoid_d = 1'b1;
                  busy_d     = 1'b1;
               end
            end
         end

         S_PULSE: begin
            timer_d = timer_inc;
            if (sense_hit) begin
               count_d  = count_q + 5'd1;
               sensed_d = 1'b1;
            end
            if (timer_q == PULSE_LAST) begin
               solenoid_d = 1'b0;
               if (sensed_q || sense_hit) begin
                  state_d = S_GAP;
                  timer_d = '0;
               end else begin
                  // Timer keeps running from pulse start for the timeout.
                  state_d = S_WAIT_SENSE;
               end
            end
         end

         S_WAIT_SENSE: begin
            timer_d = timer_inc;
            // A sensor edge on the timeout cycle takes priority over the jam.
            if (sense_hit) begin
               count_d  = count_q + 5'd1;
               sensed_d = 1'b1;
               state_d  = S_GAP;
               timer_d  = '0;
            end else if (timer_inc == TIMEOUT_T) begin
               state_d = S_FAULT;
               fault_d = FAULT_JAM;
               busy_d  = 1'b0;
            end
         end

         S_GAP: begin
            timer_d = timer_inc;
            if (timer_q == GAP_LAST) begin
               timer_d = '0;
               if (count_q == target_q) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
               end else if (tubeEmpty) begin
                  state_d = S_FAULT;
                  fault_d = FAULT_EMPTY;
                  busy_d  = 1'b0;
               end else begin
                  state_d    = S_PULSE;
                  sensed_d   = 1'b0;
                  solenoid_d = 1'b1;
               end
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         S_FAULT: begin
            solenoid_d = 1'b0;
            busy_d     = 1'b0;
            if (clearFault) begin
               fault_d = FAULT_NONE;
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d    = S_IDLE;
            solenoid_d = 1'b0;
            busy_d     = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!resetN) begin
         state_q      <= S_IDLE;
         solenoid_q   <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         fault_q      <= FAULT_NONE;
         count_q      <= 5'd0;
         target_q     <= 5'd0;
         timer_q      <= '0;
         sensed_q     <= 1'b0;
         start_prev_q <= 1'b0;
         sense_prev_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         solenoid_q   <= solenoid_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         fault_q      <= fault_d;
         count_q      <= count_d;
         target_q     <= target_d;
         timer_q      <= timer_d;
         sensed_q     <= sensed_d;
         start_prev_q <= start_prev_d;
         sense_prev_q <= sense_prev_d;
      end
   end

   assign solenoid       = solenoid_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign fault          = fault_q;
   assign dispensedCount = count_q;

endmodule

// File: tb/tb_chip_dispense_sequencer.sv
// -----------------------------------------------------------------------------
// tb_chip_dispense_sequencer
//
// Purpose: exercises chip_dispense_sequencer with directed and randomized
// dispense transactions. Each transaction is described by a quantity code and
// a per-chip sensor delay; the expected output timeline (pulse start times,
// gap ends, done / fault cycle, running count) is computed from those with
// plain arithmetic and compared every cycle.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_chip_dispense_sequencer;

   localparam int P_ON  = 4;
   localparam int P_OFF = 3;
   localparam int TO    = 10;
   localparam int TW    = 8;

   localparam int OUT_DONE  = 0;
   localparam int OUT_EMPTY = 1;
   localparam int OUT_JAM   = 2;

   logic       clock = 1'b0;
   logic       resetN;
   logic       startIn;
   logic [1:0] quantityIn;
   logic       chipSense;
   logic       tubeEmpty;
   logic       clearFault;
   logic       solenoid;
   logic       busy;
   logic       done;
   logic [1:0] fault;
   logic [4:0] dispensedCount;

   chip_dispense_sequencer #(
      .PULSE_ON      (P_ON),
      .PULSE_OFF     (P_OFF),
      .SENSE_TIMEOUT (TO),
      .TIMER_W       (TW)
   ) dut (
      .clock          (clock),
      .resetN         (resetN),
      .startIn        (startIn),
      .quantityIn     (quantityIn),
      .chipSense      (chipSense),
      .tubeEmpty      (tubeEmpty),
      .clearFault     (clearFault),
      .solenoid       (solenoid),
      .busy           (busy),
      .done           (done),
      .fault          (fault),
      .dispensedCount (dispensedCount)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;
   int txn_id = 0;
   int cur_cyc = 0;

   int qty_tab [4] = '{1, 5, 10, 20};

   // Per-chip stimulus: sensor delay from pulse start (>= TO means jam) and
   // whether a second sensor pulse follows inside the same solenoid pulse.
   int dly [20];
   bit dbl [20];

   // Model timeline for the current transaction.
   int pstart [20];
   int gstart [20];
   int nstart;
   int end_c;
   int outcome;
   int final_count;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s txn=%0d cyc=%0d observed=%0d expected=%0d",
                tag, txn_id, cur_cyc, obs, exp);
      end
   endtask

   task automatic set_chips(input int d, input bit two);
      for (int i = 0; i < 20; i++) begin
         dly[i] = d;
         dbl[i] = two;
      end
   endtask

   function automatic int exp_count(input int c);
      int n = 0;
      for (int i = 0; i < nstart; i++)
         if (dly[i] < TO && pstart[i] + dly[i] + 1 <= c) n++;
      return n;
   endfunction

   function automatic int exp_sol(input int c);
      for (int i = 0; i < nstart; i++)
         if (c >= pstart[i] && c < pstart[i] + P_ON) return 1;
      return 0;
   endfunction

   function automatic int sense_at(input int c);
      for (int i = 0; i < nstart; i++) begin
         if (dly[i] < TO) begin
            if (c == pstart[i] + dly[i]) return 1;
            if (dbl[i] && dly[i] + 2 < P_ON && c == pstart[i] + dly[i] + 2) return 1;
         end
      end
      return 0;
   endfunction

   // Builds the expected timeline: chip i pulses at pstart[i]; its gap begins
   // after the later of the pulse end and the cycle after the sensor edge, and
   // lasts P_OFF cycles. A chip with no edge within TO cycles is a jam.
   task automatic build_model(input int qcode, input int empty_e);
      int n;
      int p;
      int g;
      n = qty_tab[qcode];
      nstart = 0;
      if (empty_e == 0) begin
         end_c   = 1;
         outcome = OUT_EMPTY;
      end else begin
         p = 1;
         for (int i = 0; i < n; i++) begin
            pstart[i] = p;
            nstart    = i + 1;
            if (dly[i] >= TO) begin
               end_c   = p + TO;
               outcome = OUT_JAM;
               break;
            end
            g = p + ((dly[i] + 1 > P_ON) ? dly[i] + 1 : P_ON);
            gstart[i] = g;
            if (i == n - 1) begin
               end_c   = g + P_OFF;
               outcome = OUT_DONE;
            end else if (empty_e == i + 1) begin
               end_c   = g + P_OFF;
               outcome = OUT_EMPTY;
               break;
            end else begin
               p = g + P_OFF;
            end
         end
      end
      final_count = exp_count(end_c);
   endtask

   task automatic clear_seq();
      int fcode;
      fcode = (outcome == OUT_JAM) ? 2 : 1;
      @(negedge clock);
      check("fault_held", fault, fcode);
      startIn = 1'b1;
      @(negedge clock);
      check("fault_held2", fault, fcode);
      check("busy_fault", busy, 0);
      check("sol_fault", solenoid, 0);
      clearFault = 1'b1;
      @(negedge clock);
      check("fault_cleared", fault, 0);
      clearFault = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         check("no_retrigger_busy", busy, 0);
         check("no_retrigger_sol", solenoid, 0);
         check("count_after_clear", dispensedCount, final_count);
      end
      startIn = 1'b0;
      @(negedge clock);
   endtask

   task automatic run_txn(input int qcode, input int empty_e, input bit abuse);
      int hold;
      int fexp;
      txn_id++;
      build_model(qcode, empty_e);
      hold = abuse ? 2 : 1;
      fexp = (outcome == OUT_JAM) ? 2 : ((outcome == OUT_EMPTY) ? 1 : 0);
      for (int c = 0; c <= end_c + 2; c++) begin
         @(negedge clock);
         cur_cyc = c;
         if (c >= 1) begin
            check("solenoid", solenoid, exp_sol(c));
            check("busy", busy, (empty_e != 0 && c < end_c) ? 1 : 0);
            check("done", done, (outcome == OUT_DONE && c == end_c) ? 1 : 0);
            check("fault", fault, (c >= end_c) ? fexp : 0);
            check("count", dispensedCount, exp_count(c));
         end
         if (c < hold)
            startIn = 1'b1;
         else if (abuse && c < end_c - 2)
            startIn = ($urandom_range(0, 3) == 0);
         else
            startIn = 1'b0;
         quantityIn = (abuse && c > 0) ? 2'($urandom_range(0, 3)) : 2'(qcode);
         chipSense  = sense_at(c) != 0;
         if (empty_e == 0)
            tubeEmpty = (c == 0);
         else if (outcome == OUT_EMPTY && empty_e > 0)
            tubeEmpty = (c >= gstart[empty_e - 1]);
         else
            tubeEmpty = 1'b0;
      end
      chipSense = 1'b0;
      tubeEmpty = 1'b0;
      $display("txn %0d qcode=%0d chips_started=%0d outcome=%0d end_cycle=%0d count=%0d",
               txn_id, qcode, nstart, outcome, end_c, final_count);
      if (outcome != OUT_DONE) clear_seq();
   endtask

   task automatic reset_mid_pulse();
      txn_id++;
      @(negedge clock);
      quantityIn = 2'b01;
      startIn    = 1'b1;
      @(negedge clock);
      check("rst_pre_sol", solenoid, 1);
      startIn = 1'b0;
      @(negedge clock);
      resetN = 1'b0;
      @(negedge clock);
      check("rst_sol", solenoid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_fault", fault, 0);
      check("rst_count", dispensedCount, 0);
      resetN = 1'b1;
      repeat (2) @(negedge clock);
      check("rst_idle_sol", solenoid, 0);
      $display("txn %0d reset mid-pulse", txn_id);
   endtask

   initial begin
      int q;
      int e;
      int r;
      resetN     = 1'b0;
      startIn    = 1'b0;
      quantityIn = 2'b00;
      chipSense  = 1'b0;
      tubeEmpty  = 1'b0;
      clearFault = 1'b0;
      repeat (2) @(negedge clock);
      check("reset_sol", solenoid, 0);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_fault", fault, 0);
      check("reset_count", dispensedCount, 0);
      resetN = 1'b1;
      @(negedge clock);

      // Single chip, sensor 2 cycles into the pulse.
      set_chips(2, 1'b0);
      run_txn(0, -1, 1'b0);
      // Five chips with quantity and start toggling during the run.
      set_chips(1, 1'b0);
      run_txn(1, -1, 1'b1);
      // Jam, cleared, then a normal single chip.
      set_chips(TO, 1'b0);
      run_txn(0, -1, 1'b0);
      set_chips(0, 1'b0);
      run_txn(0, -1, 1'b0);
      // Empty tube at start.
      run_txn(0, 0, 1'b0);
      // Tube empties after chip 2 of 5.
      set_chips(3, 1'b0);
      run_txn(1, 2, 1'b0);
      // Double sensor pulses inside each solenoid pulse.
      set_chips(0, 1'b1);
      run_txn(1, -1, 1'b0);
      // Sensor edge on the timeout cycle.
      set_chips(TO - 1, 1'b0);
      run_txn(0, -1, 1'b0);
      // Reset in the middle of a pulse.
      reset_mid_pulse();

      // Randomized transactions.
      for (int t = 0; t < 20; t++) begin
         q = $urandom_range(0, 3);
         for (int i = 0; i < 20; i++) begin
            r = $urandom_range(0, 39);
            if (r < 30)      dly[i] = $urandom_range(0, P_ON - 1);
            else if (r < 39) dly[i] = $urandom_range(P_ON, TO - 1);
            else             dly[i] = TO;
            dbl[i] = ($urandom_range(0, 3) == 0);
         end
         r = $urandom_range(0, 5);
         if (r == 0)                         e = 0;
         else if (r == 1 && qty_tab[q] > 1)  e = $urandom_range(1, qty_tab[q] - 1);
         else                                e = -1;
         run_txn(q, e, $urandom_range(0, 1) == 1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
